// File: rtl/czono_affine_image.sv
// czono_affine_image: affine image of a constrained zonotope, c' = R*c (+ t), G' = R*G.
// One float multiply-add per cycle; accumulator kept in FloPoCo format (exn,sign,exp,frac).
module czono_affine_image #(
   parameter int NMAX       = 3,
   parameter int NRMAX      = 3,
   parameter int NGMAX      = 15,
   parameter int NCMAX      = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         affine_i,
   input  logic [$clog2(NMAX+1)-1:0]    n_i,
   input  logic [$clog2(NMAX+1)-1:0]    rn_i,
   input  logic [$clog2(NRMAX+1)-1:0]   nr_i,
   input  logic [$clog2(NGMAX+1)-1:0]   ng_i,
   input  logic [$clog2(NCMAX+1)-1:0]   nc_i,
   output logic [$clog2(NRMAX)-1:0]     rd_row_o,
   output logic [$clog2(NMAX)-1:0]      rd_k_o,
   output logic [$clog2(NGMAX)-1:0]     rd_gen_o,
   input  logic [DATA_WIDTH-1:0]        r_data_i,
   input  logic [DATA_WIDTH-1:0]        zc_data_i,
   input  logic [DATA_WIDTH-1:0]        zg_data_i,
   input  logic [DATA_WIDTH-1:0]        t_data_i,
   output logic                         wr_en_o,
   output logic                         wr_sel_o,
   output logic [$clog2(NRMAX)-1:0]     wr_row_o,
   output logic [$clog2(NGMAX)-1:0]     wr_col_o,
   output logic [DATA_WIDTH-1:0]        wr_data_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [$clog2(NRMAX+1)-1:0]   out_n_o,
   output logic [$clog2(NGMAX+1)-1:0]   out_ng_o,
   output logic [$clog2(NCMAX+1)-1:0]   out_nc_o
);

   localparam int NW  = $clog2(NMAX+1);
   localparam int RW  = $clog2(NRMAX+1);
   localparam int GW  = $clog2(NGMAX+1);
   localparam int CW  = $clog2(NCMAX+1);
   localparam int RIW = $clog2(NRMAX);
   localparam int KIW = $clog2(NMAX);
   localparam int GIW = $clog2(NGMAX);
   localparam int FW  = DATA_WIDTH + 2;

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("czono_affine_image: DATA_WIDTH must be 32");
   end

   typedef logic [FW-1:0] fp_t;
   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_MAC, S_FLUSH, S_DONE
   } state_t;

   localparam fp_t FP_ZERO = '0;
   localparam fp_t FP_NAN  = {2'b11, 32'd0};
   localparam logic [GW-1:0]  ONE_G = GW'(1);
   localparam logic [RIW-1:0] ONE_R = RIW'(1);
   localparam logic [KIW-1:0] ONE_K = KIW'(1);

   // exn: 00 zero, 01 normal, 10 inf, 11 nan; subnormal inputs flush to zero
   function automatic fp_t ieee2fp(input logic [31:0] x);
      logic [1:0] ex;
      if (x[30:23] == 8'd0)
         ex = 2'b00;
      else if (x[30:23] == 8'hFF)
         ex = (x[22:0] == 23'd0) ? 2'b10 : 2'b11;
      else
         ex = 2'b01;
      return {ex, x};
   endfunction

   function automatic logic [31:0] fp2ieee(input fp_t y);
      case (y[33:32])
         2'b00:   return {y[31], 31'd0};
         2'b01:   return y[31:0];
         2'b10:   return {y[31], 8'hFF, 23'd0};
         default: return {1'b0, 8'hFF, 23'h400000};
      endcase
   endfunction

   // round to nearest even, then range-check the 11-bit two's-complement exponent
   function automatic fp_t round_pack(input logic s, input logic [10:0] e,
                                      input logic [22:0] m, input logic g,
                                      input logic st);
      logic [23:0] mr;
      logic [10:0] ee;
      mr = {1'b0, m} + 24'(g & (st | m[0]));
      ee = e;
      if (mr[23])
         ee = ee + 11'd1;
      if (ee[10] || ee == 11'd0)
         return {2'b00, s, 31'd0};
      if (ee >= 11'd255)
         return {2'b10, s, 31'd0};
      return {2'b01, s, ee[7:0], mr[22:0]};
   endfunction

   function automatic fp_t fp_mul(input fp_t a, input fp_t b);
      logic        s;
      logic [47:0] p;
      logic [22:0] m;
      logic        g;
      logic        st;
      logic [10:0] e;
      s = a[31] ^ b[31];
      if (a[33:32] == 2'b11 || b[33:32] == 2'b11)
         return FP_NAN;
      if (a[33:32] == 2'b10 || b[33:32] == 2'b10) begin
         if (a[33:32] == 2'b00 || b[33:32] == 2'b00)
            return FP_NAN;
         return {2'b10, s, 31'd0};
      end
      if (a[33:32] == 2'b00 || b[33:32] == 2'b00)
         return {2'b00, s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 11'(a[30:23]) + 11'(b[30:23]) - 11'd127;
      if (p[47]) begin
         m  = p[46:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 11'd1;
      end else begin
         m  = p[45:23];
         g  = p[22];
         st = |p[21:0];
      end
      return round_pack(s, e, m, g, st);
   endfunction

   function automatic fp_t fp_add(input fp_t a, input fp_t b);
      fp_t         x;
      fp_t         y;
      logic [7:0]  d;
      logic [26:0] mx;
      logic [26:0] my;
      logic [53:0] tmp;
      logic [27:0] sm;
      logic [25:0] mn;
      logic [10:0] e;
      int          lz;
      logic        found;
      if (a[33:32] == 2'b11 || b[33:32] == 2'b11)
         return FP_NAN;
      if (a[33:32] == 2'b10 && b[33:32] == 2'b10)
         return (a[31] != b[31]) ? FP_NAN : a;
      if (a[33:32] == 2'b10)
         return a;
      if (b[33:32] == 2'b10)
         return b;
      if (a[33:32] == 2'b00 && b[33:32] == 2'b00)
         return {2'b00, a[31] & b[31], 31'd0};
      if (a[33:32] == 2'b00)
         return b;
      if (b[33:32] == 2'b00)
         return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      if (d > 8'd26) begin
         my = 27'd1;
      end else begin
         tmp = {1'b1, y[22:0], 3'b000, 27'd0} >> d;
         my  = {tmp[53:28], tmp[27] | (|tmp[26:0])};
      end
      if (x[31] == y[31])
         sm = {1'b0, mx} + {1'b0, my};
      else
         sm = {1'b0, mx} - {1'b0, my};
      if (sm == 28'd0)
         return FP_ZERO;
      e = {3'b000, x[30:23]};
      if (sm[27]) begin
         mn = {sm[26:2], sm[1] | sm[0]};
         e  = e + 11'd1;
      end else begin
         lz    = 0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sm[i])
                  found = 1'b1;
               else
                  lz = lz + 1;
            end
         end
         mn = 26'(sm[26:0] << lz);
         e  = e - 11'(lz);
      end
      return round_pack(x[31], e, mn[25:3], mn[2], |mn[1:0]);
   endfunction

   state_t state_q;
   state_t state_d;

   logic            aff_q;
   logic [NW-1:0]   n_q;
   logic [NW-1:0]   rn_q;
   logic [RW-1:0]   nr_q;
   logic [GW-1:0]   ng_q;
   logic [CW-1:0]   nc_q;
   logic [RIW-1:0]  r_q;
   logic [GW-1:0]   j_q;
   logic [KIW-1:0]  k_q;
   fp_t             acc_q;

   logic            wr_en_q;
   logic            wr_sel_q;
   logic [RIW-1:0]  wr_row_q;
   logic [GIW-1:0]  wr_col_q;
   logic [31:0]     wr_data_q;
   logic            err_q;
   logic [RW-1:0]   out_n_q;
   logic [GW-1:0]   out_ng_q;
   logic [CW-1:0]   out_nc_q;

   logic dim_err;
   logic k_last;
   logic j_last;
   logic r_last;
   fp_t  r_f;
   fp_t  d_f;
   fp_t  t_f;
   fp_t  seed;
   fp_t  sum;

   assign dim_err = (n_q == '0) || (nr_q == '0) || (ng_q == '0) ||
                    (rn_q != n_q) || (int'(n_q) > NMAX) ||
                    (int'(nr_q) > NRMAX) || (int'(ng_q) > NGMAX) ||
                    (int'(nc_q) > NCMAX);

   // j_q == 0 is the center pass, j_q == g+1 is generator column g
   assign k_last = int'(k_q) == int'(n_q) - 1;
   assign j_last = int'(j_q) == int'(ng_q);
   assign r_last = int'(r_q) == int'(nr_q) - 1;

   assign r_f  = ieee2fp(r_data_i);
   assign d_f  = ieee2fp((j_q == '0) ? zc_data_i : zg_data_i);
   assign t_f  = ieee2fp(t_data_i);
   assign seed = (k_q != '0) ? acc_q :
                 ((j_q == '0 && aff_q) ? t_f : FP_ZERO);
   assign sum  = fp_add(seed, fp_mul(r_f, d_f));

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_i) state_d = S_CHECK;
         S_CHECK: state_d = dim_err ? S_DONE : S_MAC;
         S_MAC:   if (k_last && j_last && r_last) state_d = S_FLUSH;
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o   = state_q != S_IDLE;
      done_o   = state_q == S_DONE;
      rd_row_o = '0;
      rd_k_o   = '0;
      rd_gen_o = '0;
      if (state_q == S_MAC) begin
         rd_row_o = r_q;
         rd_k_o   = k_q;
         if (j_q != '0)
            rd_gen_o = GIW'(j_q - ONE_G);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aff_q     <= 1'b0;
         n_q       <= '0;
         rn_q      <= '0;
         nr_q      <= '0;
         ng_q      <= '0;
         nc_q      <= '0;
         r_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         acc_q     <= FP_ZERO;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 1'b0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         out_n_q   <= '0;
         out_ng_q  <= '0;
         out_nc_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (state_q == S_IDLE && start_i) begin
            aff_q <= affine_i;
            n_q   <= n_i;
            rn_q  <= rn_i;
            nr_q  <= nr_i;
            ng_q  <= ng_i;
            nc_q  <= nc_i;
            err_q <= 1'b0;
         end
         if (state_q == S_CHECK) begin
            err_q <= dim_err;
            r_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
         end
         if (state_q == S_MAC) begin
            if (k_last) begin
               wr_en_q   <= 1'b1;
               wr_sel_q  <= j_q != '0;
               wr_row_q  <= r_q;
               wr_col_q  <= (j_q != '0) ? GIW'(j_q - ONE_G) : '0;
               wr_data_q <= fp2ieee(sum);
               k_q       <= '0;
               if (j_last) begin
                  j_q <= '0;
                  r_q <= r_last ? '0 : r_q + ONE_R;
               end else begin
                  j_q <= j_q + ONE_G;
               end
            end else begin
               acc_q <= sum;
               k_q   <= k_q + ONE_K;
            end
         end
         if (state_d == S_DONE && state_q != S_DONE) begin
            out_n_q  <= nr_q;
            out_ng_q <= ng_q;
            out_nc_q <= nc_q;
         end
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_sel_o  = wr_sel_q;
   assign wr_row_o  = wr_row_q;
   assign wr_col_o  = wr_col_q;
   assign wr_data_o = wr_data_q;
   assign err_o     = err_q;
   assign out_n_o   = out_n_q;
   assign out_ng_o  = out_ng_q;
   assign out_nc_o  = out_nc_q;

endmodule

// File: tb/tb_czono_affine_image.sv
// tb_czono_affine_image: directed + random jobs against a real-arithmetic matrix model.
// Operand values are exact binary fractions so the real sums are exact in float32.
module tb_czono_affine_image;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        affine_i;
   logic [1:0]  n_i;
   logic [1:0]  rn_i;
   logic [1:0]  nr_i;
   logic [3:0]  ng_i;
   logic [3:0]  nc_i;
   logic [1:0]  rd_row_o;
   logic [1:0]  rd_k_o;
   logic [3:0]  rd_gen_o;
   logic [31:0] r_data_i;
   logic [31:0] zc_data_i;
   logic [31:0] zg_data_i;
   logic [31:0] t_data_i;
   logic        wr_en_o;
   logic        wr_sel_o;
   logic [1:0]  wr_row_o;
   logic [3:0]  wr_col_o;
   logic [31:0] wr_data_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [1:0]  out_n_o;
   logic [3:0]  out_ng_o;
   logic [3:0]  out_nc_o;

   logic [31:0] rm  [3][3];
   logic [31:0] zcm [3];
   logic [31:0] zgm [3][15];
   logic [31:0] tm  [3];
   real rr  [3][3];
   real zcr [3];
   real zgr [3][15];
   real tr  [3];
   real vals [12] = '{0.0, 0.5, 1.0, 1.5, 2.0, -1.0,
                      -0.25, 3.0, -2.5, 0.75, -4.0, 1.25};

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [60:0] wq[$];
   logic [60:0] eq[$];

   czono_affine_image dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .affine_i(affine_i),
      .n_i(n_i), .rn_i(rn_i), .nr_i(nr_i), .ng_i(ng_i), .nc_i(nc_i),
      .rd_row_o(rd_row_o), .rd_k_o(rd_k_o), .rd_gen_o(rd_gen_o),
      .r_data_i(r_data_i), .zc_data_i(zc_data_i), .zg_data_i(zg_data_i),
      .t_data_i(t_data_i), .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o),
      .wr_row_o(wr_row_o), .wr_col_o(wr_col_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .out_n_o(out_n_o), .out_ng_o(out_ng_o), .out_nc_o(out_nc_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign r_data_i  = rm[rd_row_o][rd_k_o];
   assign zc_data_i = zcm[rd_k_o];
   assign zg_data_i = zgm[rd_k_o][rd_gen_o];
   assign t_data_i  = tm[rd_row_o];

   // write record: {abs cycle[15:0], sel, row[3:0], col[7:0], data[31:0]}
   always @(negedge clk)
      if (wr_en_o)
         wq.push_back({16'(cyc), wr_sel_o, 4'(wr_row_o), 8'(wr_col_o), wr_data_o});

   function automatic logic [31:0] r2f(input real v);
      real    a;
      int     e;
      longint f;
      logic   s;
      if (v == 0.0) return 32'd0;
      s = v < 0.0;
      a = s ? -v : v;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      f = longint'((a - 1.0) * 8388608.0);
      return {s, 8'(e), 23'(f)};
   endfunction

   function automatic logic [63:0] outs_vec();
      return 64'({busy_o, done_o, err_o, wr_en_o, wr_sel_o, wr_row_o,
                  wr_col_o, wr_data_o, rd_row_o, rd_k_o, rd_gen_o,
                  out_n_o, out_ng_o, out_nc_o});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sync_bits();
      for (int i = 0; i < 3; i++) begin
         zcm[i] = r2f(zcr[i]);
         tm[i]  = r2f(tr[i]);
         for (int k = 0; k < 3; k++) rm[i][k] = r2f(rr[i][k]);
         for (int j = 0; j < 15; j++) zgm[i][j] = r2f(zgr[i][j]);
      end
   endtask

   task automatic fill(input bit rnd, input real v);
      for (int i = 0; i < 3; i++) begin
         zcr[i] = rnd ? vals[$urandom_range(0, 11)] : v;
         tr[i]  = rnd ? vals[$urandom_range(0, 11)] : v;
         for (int k = 0; k < 3; k++)
            rr[i][k] = rnd ? vals[$urandom_range(0, 11)] : v;
         for (int j = 0; j < 15; j++)
            zgr[i][j] = rnd ? vals[$urandom_range(0, 11)] : v;
      end
      sync_bits();
   endtask

   // out = R*Z (+t), in row-major write order; write w lands at cycle 2+(w+1)*n
   task automatic build_exp(input bit aff, input int n, input int nr, input int ng);
      real s;
      int  w;
      w = 0;
      eq.delete();
      for (int r = 0; r < nr; r++)
         for (int j = -1; j < ng; j++) begin
            s = (j < 0 && aff) ? tr[r] : 0.0;
            for (int k = 0; k < n; k++)
               s = s + rr[r][k] * ((j < 0) ? zcr[k] : zgr[k][j]);
            w++;
            eq.push_back({16'(2 + w * n), j >= 0, 4'(r),
                          8'((j < 0) ? 0 : j), r2f(s)});
         end
   endtask

   task automatic run_job(input string tag, input bit aff, input int n,
                          input int rn, input int nr, input int ng,
                          input int nc, input bit exp_err, input bit model);
      int base;
      int dc;
      bit seen;
      logic [60:0] w;
      if (exp_err) eq.delete();
      else if (model) build_exp(aff, n, nr, ng);
      wq.delete();
      @(negedge clk);
      start_i = 1'b1; affine_i = aff;
      n_i = 2'(n); rn_i = 2'(rn); nr_i = 2'(nr);
      ng_i = 4'(ng); nc_i = 4'(nc);
      @(negedge clk);
      base = cyc;
      start_i = 1'b0;
      chk({tag, " check busy/err"}, {busy_o, err_o}, 2'b10);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done_o) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      dc = cyc - base + 1;
      chk({tag, " done seen"}, seen, 1);
      chk({tag, " done cycle"}, dc, exp_err ? 2 : 3 + nr * n * (ng + 1));
      chk({tag, " err"}, err_o, exp_err);
      if (!exp_err)
         chk({tag, " out dims"}, {out_n_o, out_ng_o, out_nc_o},
             {2'(nr), 4'(ng), 4'(nc)});
      chk({tag, " write count"}, wq.size(), eq.size());
      for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
         w = wq[i];
         w[60:45] = 16'(int'(w[60:45]) - base + 1);
         chk($sformatf("%s wr%0d", tag, i), w, eq[i]);
      end
      @(negedge clk);
      chk({tag, " idle after"}, {busy_o, done_o, wr_en_o}, 3'b000);
   endtask

   initial begin
      int n, nr, ng, sel, dq[$], iq[$], stray, idle_exp, last;
      rst_i = 1'b1; start_i = 1'b0; affine_i = 1'b0;
      n_i = '0; rn_i = '0; nr_i = '0; ng_i = '0; nc_i = '0;
      fill(1'b0, 0.0);
      repeat (3) @(negedge clk);
      chk("reset outputs", outs_vec(), 64'd0);
      rst_i = 1'b0;

      fill(1'b0, 0.0);
      rr[0][0] = 1.0; rr[0][1] = 2.0; rr[1][0] = 0.0; rr[1][1] = 1.0;
      zcr[0] = 1.0; zcr[1] = 1.0; zgr[0][0] = 1.0; zgr[1][0] = 0.5;
      tr[0] = 0.5; tr[1] = 0.0;
      sync_bits();
      eq.delete();
      eq.push_back({16'd4,  1'b0, 4'd0, 8'd0, 32'h40600000});
      eq.push_back({16'd6,  1'b1, 4'd0, 8'd0, 32'h40000000});
      eq.push_back({16'd8,  1'b0, 4'd1, 8'd0, 32'h3F800000});
      eq.push_back({16'd10, 1'b1, 4'd1, 8'd0, 32'h3F000000});
      run_job("ex_affine", 1'b1, 2, 2, 2, 1, 0, 1'b0, 1'b0);
      eq[0][31:0] = 32'h40400000;
      run_job("ex_linear", 1'b0, 2, 2, 2, 1, 0, 1'b0, 1'b0);

      run_job("err_rn", 1'b0, 2, 3, 2, 1, 0, 1'b1, 1'b0);
      run_job("after_err", 1'b1, 2, 2, 2, 1, 5, 1'b0, 1'b1);

      fill(1'b0, 1.0);
      run_job("max_dims", 1'b0, 3, 3, 3, 15, 12, 1'b0, 1'b1);

      for (int t = 0; t < 6; t++) begin
         fill(1'b1, 0.0);
         n  = $urandom_range(1, 3);
         nr = $urandom_range(1, 3);
         ng = $urandom_range(1, 15);
         run_job($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), n, n, nr, ng,
                 $urandom_range(0, 12), 1'b0, 1'b1);
      end

      for (int t = 0; t < 4; t++) begin
         sel = t;
         run_job($sformatf("bad%0d", t), 1'b1,
                 (sel == 0) ? 0 : 2, (sel == 0) ? 0 : 2,
                 (sel == 1) ? 0 : 2, (sel == 2) ? 0 : 3,
                 (sel == 3) ? $urandom_range(13, 15) : 4, 1'b1, 1'b0);
      end

      fill(1'b0, 1.0);
      @(negedge clk);
      start_i = 1'b1; affine_i = 1'b1;
      n_i = 2'd3; rn_i = 2'd3; nr_i = 2'd3; ng_i = 4'd15; nc_i = 4'd2;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("mid reset outputs", outs_vec(), 64'd0);
      wq.delete();
      repeat (12) @(negedge clk);
      chk("no writes after reset", wq.size(), 0);
      chk("idle after reset", busy_o, 1'b0);
      fill(1'b1, 0.0);
      run_job("post_reset", 1'b1, 3, 3, 2, 4, 7, 1'b0, 1'b1);

      @(negedge clk);
      start_i = 1'b1; affine_i = 1'b0;
      n_i = 2'd1; rn_i = 2'd1; nr_i = 2'd1; ng_i = 4'd1; nc_i = 4'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) dq.push_back(cyc);
         if (!busy_o) iq.push_back(cyc);
      end
      last = cyc;
      start_i = 1'b0;
      chk("held done count", dq.size() >= 5, 1);
      for (int i = 0; i + 1 < dq.size(); i++)
         chk($sformatf("held interval%0d", i), dq[i + 1] - dq[i], 6);
      idle_exp = 0;
      foreach (dq[i]) if (dq[i] + 1 <= last) idle_exp++;
      stray = 0;
      foreach (iq[i]) begin
         int hit;
         hit = 0;
         foreach (dq[m]) if (dq[m] + 1 == iq[i]) hit = 1;
         if (hit == 0) stray++;
      end
      chk("held idle count", iq.size(), idle_exp);
      chk("held stray idle", stray, 0);
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
